// File: rtl/tdm_demux4_pkg.sv
// rtl/tdm_demux4_pkg.sv - shared defaults, state type and lane helpers for tdm_demux4
package tdm_demux4_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_LANES = 2;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_e;

   function automatic int ptr_width(input int lanes);
      int w;
      w = 1;
      while ((1 << w) < lanes) w++;
      return w;
   endfunction

   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/tdm_lane_reg.sv
// rtl/tdm_lane_reg.sv - one staging lane: write-enabled register with async active-low clear
module tdm_lane_reg
   import tdm_demux4_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] q_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else if (we_i) begin
         q_q <= d_i;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - round-robin TDM beat demultiplexer with atomic frame publish
// Optional parity checking is built when TDM_DEMUX4_PARITY_EN is defined.
module tdm_demux4
   import tdm_demux4_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int LANES = DEF_LANES
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [WIDTH-1:0]       din,
   input  logic                   din_valid,
   input  logic                   sof,
   output logic [LANES*WIDTH-1:0] dout,
   output logic                   frame_valid,
   output logic                   sync_err,
   output logic                   busy
`ifdef TDM_DEMUX4_PARITY_EN
   ,
   input  logic                   din_par,
   output logic                   par_err
`endif
);

   localparam int              PTR_W = ptr_width(LANES);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(LANES - 1);

   state_e                 state_q;
   logic [PTR_W-1:0]       ptr_q;
   logic [PTR_W-1:0]       wr_lane;
   logic                   acc;
   logic                   restart;
   logic                   last_beat;
   logic [WIDTH-1:0]       lane_q [LANES];
   logic [LANES-1:0]       lane_we;
   logic [LANES*WIDTH-1:0] dout_q;
   logic [LANES*WIDTH-1:0] pub_d;
   logic                   fv_q;
   logic                   se_q;

   assign acc       = enable && din_valid;
   // Any beat seen in IDLE, or a sof beat in FILL, opens a fresh frame at lane 0.
   assign restart   = (state_q == IDLE) || sof;
   assign wr_lane   = restart ? '0 : ptr_q;
   assign last_beat = !restart && (ptr_q == LAST);

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign lane_we[k] = acc && (wr_lane == PTR_W'(k));
      tdm_lane_reg #(.WIDTH(WIDTH)) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .we_i  (lane_we[k]),
         .d_i   (din),
         .q_o   (lane_q[k])
      );
   end

   // The final beat bypasses its staging lane so the whole frame publishes on one edge.
   always_comb begin
      pub_d = '0;
      for (int k = 0; k < LANES; k++) begin
         pub_d[lane_lsb(k, WIDTH) +: WIDTH] = lane_we[k] ? din : lane_q[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         dout_q  <= '0;
         fv_q    <= 1'b0;
         se_q    <= 1'b0;
      end else begin
         fv_q <= 1'b0;
         se_q <= 1'b0;
         if (acc) begin
            if (state_q == IDLE) begin
               ptr_q   <= PTR_W'(1);
               state_q <= FILL;
            end else if (sof) begin
               se_q  <= 1'b1;
               ptr_q <= PTR_W'(1);
            end else if (last_beat) begin
               dout_q  <= pub_d;
               fv_q    <= 1'b1;
               ptr_q   <= '0;
               state_q <= IDLE;
            end else begin
               ptr_q <= ptr_q + PTR_W'(1);
            end
         end
      end
   end

`ifdef TDM_DEMUX4_PARITY_EN
   logic flag_q;
   logic pe_q;
   logic frame_bad;

   assign frame_bad = (^{din, din_par}) || (flag_q && !restart);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_q <= 1'b0;
         pe_q   <= 1'b0;
      end else begin
         pe_q <= 1'b0;
         if (acc) begin
            flag_q <= frame_bad;
            if (last_beat) pe_q <= frame_bad;
         end
      end
   end

   assign par_err = enable && pe_q;
`endif

   assign dout        = enable ? dout_q : '0;
   assign frame_valid = enable && fv_q;
   assign sync_err    = enable && se_q;
   assign busy        = enable && (state_q == FILL);

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - scoreboard bench for tdm_demux4 with a frame-level reference model
module tb_tdm_demux4;
   import tdm_demux4_pkg::*;

   localparam int W = DEF_WIDTH;
   localparam int L = DEF_LANES;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           enable = 1'b0;
   logic           din_valid = 1'b0;
   logic           sof = 1'b0;
   logic [W-1:0]   din = '0;
   logic [L*W-1:0] dout;
   logic           frame_valid;
   logic           sync_err;
   logic           busy;
`ifdef TDM_DEMUX4_PARITY_EN
   logic           din_par = 1'b0;
   logic           par_err;
`endif

   always #5 clk = ~clk;

   tdm_demux4 #(.WIDTH(W), .LANES(L)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .din         (din),
      .din_valid   (din_valid),
      .sof         (sof),
      .dout        (dout),
      .frame_valid (frame_valid),
      .sync_err    (sync_err),
      .busy        (busy)
`ifdef TDM_DEMUX4_PARITY_EN
      ,
      .din_par     (din_par),
      .par_err     (par_err)
`endif
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: a frame is just the list of beats collected so far.
   logic [W-1:0]   frame_beats[$];
   bit             frame_bad;
   logic [L*W-1:0] last_pub = '0;
   logic [L*W-1:0] exp_frame_q[$];
   bit             exp_par_q[$];
   int             exp_se_q[$];
   bit             pend_fv, pend_se, pend_par;
   logic [L*W-1:0] pend_val;

   function automatic void model_beat(input bit s, input logic [W-1:0] d, input bit p);
      bit bad;
      bad = (^d) ^ p;
      if (s && frame_beats.size() > 0) begin
         pend_se = 1'b1;
         frame_beats.delete();
      end
      if (frame_beats.size() == 0) frame_bad = 1'b0;
      frame_beats.push_back(d);
      frame_bad = frame_bad | bad;
      if (frame_beats.size() == L) begin
         pend_val = '0;
         for (int k = 0; k < L; k++) pend_val[k*W +: W] = frame_beats[k];
         last_pub = pend_val;
         pend_fv  = 1'b1;
         pend_par = frame_bad;
         frame_beats.delete();
      end
   endfunction

   function automatic void model_reset();
      frame_beats.delete();
      exp_frame_q.delete();
      exp_par_q.delete();
      exp_se_q.delete();
      frame_bad = 1'b0;
      last_pub  = '0;
      pend_fv   = 1'b0;
      pend_se   = 1'b0;
   endfunction

   // Pulses from the previous edge are only observable if enable is high in this cycle.
   task automatic cycle(input bit en, input bit v, input bit s, input logic [W-1:0] d, input bit p);
      enable    = en;
      din_valid = v;
      sof       = s;
      din       = d;
`ifdef TDM_DEMUX4_PARITY_EN
      din_par   = p;
`endif
      if (pend_fv && en) begin
         exp_frame_q.push_back(pend_val);
         exp_par_q.push_back(pend_par);
      end
      if (pend_se && en) exp_se_q.push_back(1);
      pend_fv = 1'b0;
      pend_se = 1'b0;
      @(posedge clk);
      if (rst_n && en && v) model_beat(s, d, p);
      #1;
   endtask

   task automatic beat(input bit s, input logic [W-1:0] d);
      cycle(1'b1, 1'b1, s, d, ^d);
   endtask

   task automatic idle();
      cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
   endtask

   initial begin
      bit             exp_fv, exp_se, exp_pe;
      logic [L*W-1:0] exp_val;
      forever begin
         @(negedge clk);
         chk("dout_gated", dout, enable ? last_pub : '0);
         chk("busy", busy, enable && frame_beats.size() > 0);
         exp_fv = exp_frame_q.size() > 0;
         chk("frame_valid", frame_valid, exp_fv);
         exp_pe = 1'b0;
         if (exp_fv) begin
            exp_val = exp_frame_q.pop_front();
            exp_pe  = exp_par_q.pop_front();
            if (frame_valid) chk("frame_dout", dout, exp_val);
         end
`ifdef TDM_DEMUX4_PARITY_EN
         chk("par_err", par_err, exp_pe);
`endif
         exp_se = exp_se_q.size() > 0;
         chk("sync_err", sync_err, exp_se);
         if (exp_se) void'(exp_se_q.pop_front());
      end
   end

   initial begin
      bit           en, v, s, p;
      logic [W-1:0] d;
      model_reset();
      repeat (2) cycle(1'b1, 1'b1, 1'b0, 4'h7, 1'b1);
      chk("rst_dout", dout, 0);
      chk("rst_frame_valid", frame_valid, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      idle();

      beat(1'b1, 4'h3);
      beat(1'b0, 4'hA);
      chk("t1_dout", dout, 'hA3);
      chk("t1_frame_valid", frame_valid, 1);
      chk("t1_busy", busy, 0);
      idle();
      chk("t1_pulse_width", frame_valid, 0);

      beat(1'b0, 4'h1);
      beat(1'b0, 4'h2);
      chk("t2_first_dout", dout, 'h21);
      beat(1'b0, 4'h4);
      chk("t2_gap_frame_valid", frame_valid, 0);
      beat(1'b0, 4'h8);
      chk("t2_second_dout", dout, 'h84);
      chk("t2_second_frame_valid", frame_valid, 1);
      idle();

      beat(1'b0, 4'h5);
      beat(1'b1, 4'h6);
      chk("t3_sync_err", sync_err, 1);
      chk("t3_dout_kept", dout, 'h84);
      beat(1'b0, 4'h7);
      chk("t3_dout", dout, 'h76);
      idle();

      beat(1'b0, 4'h9);
      repeat (3) begin
         cycle(1'b0, 1'b1, 1'b0, 4'hF, 1'b0);
         chk("t4_disabled_dout", dout, 0);
      end
      beat(1'b0, 4'hC);
      chk("t4_dout", dout, 'hC9);
      idle();

      beat(1'b0, 4'h2);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("t5_async_dout", dout, 0);
      chk("t5_async_busy", busy, 0);
      idle();
      rst_n = 1'b1;
      idle();
      beat(1'b0, 4'hE);
      beat(1'b0, 4'hD);
      chk("t5_dout", dout, 'hDE);
      idle();

`ifdef TDM_DEMUX4_PARITY_EN
      cycle(1'b1, 1'b1, 1'b0, 4'h3, 1'b1);
      cycle(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
      chk("t6_par_err", par_err, 1);
      chk("t6_dout", dout, 'h03);
      beat(1'b0, 4'h1);
      beat(1'b0, 4'h6);
      chk("t6_clean_par_err", par_err, 0);
      idle();
`endif

      for (int i = 0; i < 400; i++) begin
         en = ($urandom_range(0, 9) != 0);
         v  = ($urandom_range(0, 9) < 7);
         s  = ($urandom_range(0, 6) == 0);
         d  = W'($urandom);
         p  = (^d) ^ ($urandom_range(0, 9) == 0);
         cycle(en, v, s, d, p);
      end
      repeat (3) idle();
      chk("frames_drained", exp_frame_q.size(), 0);
      chk("sync_drained", exp_se_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
